seg7_scan_reader: RTL and testbench
===================================

# seg7_scan_reader

Capture-side counterpart to the board's 7-segment display driver. Watches the multiplexed, active-low digit-select and segment bus, filters out scan transitions, decodes each stable digit pattern back to a 4-bit hex value, and assembles a 16-bit frame that it presents on a valid/ready handshake. Used for loopback self-test and for logging what the display path actually emits.

## Interface
Parameters:
- STABLE_CYCLES, 4: consecutive unchanged cycles required before a digit is accepted (range 1–255).

Ports:
- clock  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- digit_select  in  4  active-low digit enables; bit i selects digit i; digit 3 is the most significant.
- write_this  in  7  active-low segments; bit 0 = a … bit 6 = g; 7'b1111111 = blank.
- frame_data  out  16  decoded nibbles; digit i occupies bits [4i+3:4i].
- frame_blank  out  4  per-digit blank flag.
- frame_err  out  4  per-digit unrecognised-pattern flag.
- frame_valid  out  1  frame available.
- frame_ready  in  1  consumer accepts the frame.
- drop_count  out  8  dropped-frame counter; exists only with SEG7_DROP_CNT_EN.

## Operation
- Input stage: digit_select and write_this are registered once into sel_r and seg_r.
- Slot check: sel_r must contain exactly one 0. All-ones, or more than one 0, is not a slot; the stability counter clears and nothing is captured.
- Stability counter (8 bits): loads 0 when {sel_r, seg_r} differs from the previous cycle's value. Otherwise it increments, saturating at STABLE_CYCLES.
- Capture: when the counter reaches STABLE_CYCLES, decode seg_r into the slot selected by sel_r and set that slot's seen bit. A slot is captured once per stable period. Rewriting an already-seen slot overwrites it.
- Decode: standard hex glyphs 0–F, active low, with 6 and 9 including segments a and d. b, d, r and similar lowercase forms use the team glyph set in seg7_pkg.
  - 7'h7F gives value 0 with blank=1.
  - Any other pattern gives value 0 with err=1.
- Frame complete: when seen == 4'b1111 after a capture:
  - If the output register is free, or is accepted in the same cycle, copy the slot values into frame_* and set frame_valid.
  - Clear seen in both cases.
- Handshake: transfer happens on any edge where frame_valid && frame_ready. frame_data, frame_blank and frame_err stay stable while frame_valid is high and no transfer has occurred. frame_ready may be high while frame_valid is low; this has no effect.
- Overflow: if a frame completes while frame_valid is high and frame_ready is low, the new frame is dropped, the held frame is untouched, and seen clears.
- Reset mid-scan: all partial slots are discarded immediately.

## Timing
- Reset values: sel_r=4'hF, seg_r=7'h7F, counter=0, seen=0, frame_data=0, frame_blank=0, frame_err=0, frame_valid=0, drop_count=0.
- Capture latency: inputs change before edge 0 and are registered at edge 0. The slot is written at edge STABLE_CYCLES.
- frame_valid rises at the same edge that writes the fourth slot. It falls at the edge after the transfer, unless a new frame loads on that edge.
- Accept and load on the same edge: frame_valid remains 1 and the new data appears.
- Throughput: one frame per four stable periods. No bubble is added by the handshake.

## Configuration
- SEG7_DROP_CNT_EN defined: adds the drop_count port. The counter increments, saturating at 255, on every dropped frame.
- SEG7_DROP_CNT_EN undefined: the port and counter are absent. Drops are silent.

## Structure
- seg7_pkg holds:
  - SEG_0 … SEG_F and SEG_BLANK pattern constants.
  - NUM_DIGITS = 4.
  - A decoded-digit struct typedef: {err, blank, value[3:0]}.
- Sub-module seg7_pattern_decode: combinational, 7-bit pattern in, decoded-digit struct out. Verified standalone against the package constants.

## Test plan
- STABLE_CYCLES=4; scan digits 0..3 with glyphs 1, 2, 3, 4, each held 6 cycles, frame_ready=1.
  -> frame_data=16'h4321, blank=0, err=0, frame_valid high for 1 cycle.
- Glitch: hold digit 0 for 2 cycles with SEG_8, then SEG_5 for 6 cycles.
  -> slot 0 = 5; the 8 is never captured.
- digit_select=4'b1100 with SEG_0 for 10 cycles.
  -> no capture, seen unchanged, frame_valid stays 0.
- Digit 2 = 7'h7F, digit 1 = 7'b0101010, others 0.
  -> frame_blank=4'b0100, frame_err=4'b0010, frame_data=0.
- frame_ready=0 across two complete scans.
  -> first frame held unchanged, second dropped, drop_count=1 with SEG7_DROP_CNT_EN. Then raise ready on the edge a third frame completes -> transfer and new load on the same edge, frame_valid stays 1.
- Assert reset_n low after three slots are captured, release, then scan one full frame.
  -> outputs at reset values during reset. Exactly one frame results, from the post-reset scan only.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg
//   Shared definitions for the 7-segment scan reader.
//   - SEG_0 .. SEG_F, SEG_BLANK : active-low glyph patterns, bit 0 = a ... bit 6 = g
//   - NUM_DIGITS                : number of multiplexed digits on the display bus
//   - digit_t                   : decoded digit {err, blank, value[3:0]}
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef struct packed {
        logic       err;
        logic       blank;
        logic [3:0] value;
    } digit_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode
//   Combinational reverse lookup of an active-low 7-segment pattern.
//   Ports:
//     pattern  in  7   active-low segments, bit 0 = a ... bit 6 = g
//     digit    out 6   decoded digit {err, blank, value}
//   Unknown patterns decode to value 0 with err set; the all-off pattern
//   decodes to value 0 with blank set.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output digit_t     digit
);

    always_comb begin
        digit = '0;
        case (pattern)
            SEG_0:     digit.value = 4'h0;
            SEG_1:     digit.value = 4'h1;
            SEG_2:     digit.value = 4'h2;
            SEG_3:     digit.value = 4'h3;
            SEG_4:     digit.value = 4'h4;
            SEG_5:     digit.value = 4'h5;
            SEG_6:     digit.value = 4'h6;
            SEG_7:     digit.value = 4'h7;
            SEG_8:     digit.value = 4'h8;
            SEG_9:     digit.value = 4'h9;
            SEG_A:     digit.value = 4'hA;
            SEG_B:     digit.value = 4'hB;
            SEG_C:     digit.value = 4'hC;
            SEG_D:     digit.value = 4'hD;
            SEG_E:     digit.value = 4'hE;
            SEG_F:     digit.value = 4'hF;
            SEG_BLANK: digit.blank = 1'b1;
            default:   digit.err   = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader
//   Watches the multiplexed active-low display bus, waits for each digit to be
//   stable, decodes it and assembles a 4-digit frame offered on valid/ready.
//   Parameter:
//     STABLE_CYCLES  unchanged cycles required before a digit is accepted (1..255)
//   Ports:
//     clock         in  1   system clock, rising edge
//     reset_n       in  1   asynchronous active-low reset
//     digit_select  in  4   active-low digit enables, digit 3 most significant
//     write_this    in  7   active-low segments, bit 0 = a ... bit 6 = g
//     frame_data    out 16  decoded nibbles, digit i at [4i+3:4i]
//     frame_blank   out 4   per-digit blank flag
//     frame_err     out 4   per-digit unrecognised-pattern flag
//     frame_valid   out 1   frame available
//     frame_ready   in  1   consumer accepts the frame
//     drop_count    out 8   saturating dropped-frame counter (SEG7_DROP_CNT_EN only)
//   Build option:
//     SEG7_DROP_CNT_EN  adds the drop_count port and counter.
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [3:0]  digit_select,
    input  logic [6:0]  write_this,
    output logic [15:0] frame_data,
    output logic [3:0]  frame_blank,
    output logic [3:0]  frame_err,
    output logic        frame_valid,
    input  logic        frame_ready
`ifdef SEG7_DROP_CNT_EN
    ,
    output logic [7:0]  drop_count
`endif
);

    localparam logic [7:0] STABLE_TARGET = 8'(STABLE_CYCLES);

    logic [3:0]                 sel_r;
    logic [6:0]                 seg_r;
    logic [7:0]                 stable_cnt;
    logic [NUM_DIGITS-1:0]      seen;
    digit_t [NUM_DIGITS-1:0]    slots;

    logic [3:0]                 sel_active;
    logic                       is_slot;
    logic                       changed;
    logic                       capture;
    logic [1:0]                 slot_idx;
    digit_t                     decoded;
    digit_t [NUM_DIGITS-1:0]    slots_next;
    logic [NUM_DIGITS-1:0]      seen_next;
    logic                       frame_done;
    logic                       load;
    logic                       drop;
    logic [15:0]                data_next;
    logic [3:0]                 blank_next;
    logic [3:0]                 err_next;

    seg7_pattern_decode u_decode (
        .pattern (seg_r),
        .digit   (decoded)
    );

    // A slot exists only when exactly one digit enable is asserted (low).
    // "changed" looks at what the input registers are about to load, so the
    // counter restarts on the very edge a new value is registered and the
    // slot is written STABLE_CYCLES edges later.
    always_comb begin
        sel_active = ~sel_r;
        is_slot    = (sel_active != 4'h0) && ((sel_active & (sel_active - 4'h1)) == 4'h0);
        changed    = {digit_select, write_this} != {sel_r, seg_r};
        capture    = is_slot && !changed && (stable_cnt == STABLE_TARGET - 8'd1);
        slot_idx   = 2'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel_active[i]) begin
                slot_idx = 2'(i);
            end
        end
    end

    // Next slot contents include the digit captured this cycle, so the frame
    // copy below sees the fourth digit on the same edge it is written.
    always_comb begin
        slots_next = slots;
        seen_next  = seen;
        if (capture) begin
            slots_next[slot_idx] = decoded;
            seen_next[slot_idx]  = 1'b1;
        end
        frame_done = capture && (seen_next == '1);
        load       = frame_done && (!frame_valid || frame_ready);
        drop       = frame_done && frame_valid && !frame_ready;
        data_next  = '0;
        blank_next = '0;
        err_next   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            data_next[4*i +: 4] = slots_next[i].value;
            blank_next[i]       = slots_next[i].blank;
            err_next[i]         = slots_next[i].err;
        end
    end

    // Input registers, stability counter and partial-frame slots.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sel_r      <= 4'hF;
            seg_r      <= 7'h7F;
            stable_cnt <= 8'd0;
            seen       <= '0;
            slots      <= '0;
        end else begin
            sel_r <= digit_select;
            seg_r <= write_this;
            if (!is_slot || changed) begin
                stable_cnt <= 8'd0;
            end else if (stable_cnt != STABLE_TARGET) begin
                stable_cnt <= stable_cnt + 8'd1;
            end
            slots <= slots_next;
            seen  <= frame_done ? '0 : seen_next;
        end
    end

    // Output holding register; a load on the accept edge keeps valid high.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            frame_data  <= '0;
            frame_blank <= '0;
            frame_err   <= '0;
            frame_valid <= 1'b0;
        end else if (load) begin
            frame_data  <= data_next;
            frame_blank <= blank_next;
            frame_err   <= err_next;
            frame_valid <= 1'b1;
        end else if (frame_valid && frame_ready) begin
            frame_valid <= 1'b0;
        end
    end

`ifdef SEG7_DROP_CNT_EN
    // Saturating count of frames lost because the consumer was stalled.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            drop_count <= 8'd0;
        end else if (drop && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
        end
    end
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb_seg7_scan_reader
//   Bench for seg7_scan_reader with STABLE_CYCLES = 4. A frame-level model
//   tracks how long each registered bus value has been present and assembles
//   frames from its own glyph table; it is compared with the DUT every cycle.
//   Directed scans add literal expectations on the delivered frames.
//   Build option honoured: SEG7_DROP_CNT_EN.
module tb_seg7_scan_reader;

    localparam int STABLE = 4;

    logic        clock;
    logic        reset_n;
    logic [3:0]  digit_select;
    logic [6:0]  write_this;
    logic [15:0] frame_data;
    logic [3:0]  frame_blank;
    logic [3:0]  frame_err;
    logic        frame_valid;
    logic        frame_ready;
`ifdef SEG7_DROP_CNT_EN
    logic [7:0]  drop_count;
`endif

    int errors = 0;
    int checks = 0;

    seg7_scan_reader #(.STABLE_CYCLES(STABLE)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .digit_select (digit_select),
        .write_this   (write_this),
        .frame_data   (frame_data),
        .frame_blank  (frame_blank),
        .frame_err    (frame_err),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready)
`ifdef SEG7_DROP_CNT_EN
        ,
        .drop_count   (drop_count)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Active-high gfedcba hex glyphs; the bus carries their complement.
    logic [6:0] glyph_hi [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    function automatic logic [6:0] glyph(input int v);
        return ~glyph_hi[v];
    endfunction

    // Returns {err, blank, value}.
    function automatic logic [5:0] model_decode(input logic [6:0] p);
        if (p == 7'h7F) return 6'b01_0000;
        for (int v = 0; v < 16; v++) begin
            if (p == ~glyph_hi[v]) return {2'b00, 4'(v)};
        end
        return 6'b10_0000;
    endfunction

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [10:0] m_reg;
    int          m_since;
    int          m_edge = 0;
    logic [5:0]  m_slot [4];
    logic [3:0]  m_seen;
    logic        m_valid;
    logic [15:0] m_data;
    logic [3:0]  m_fblank;
    logic [3:0]  m_ferr;
    int          m_drops;
    logic [10:0] m_in;
    int          m_idx;
    logic        m_took;
    logic        m_loaded;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_reg    = {4'hF, 7'h7F};
            m_since  = m_edge;
            m_seen   = 4'h0;
            m_valid  = 1'b0;
            m_data   = '0;
            m_fblank = '0;
            m_ferr   = '0;
            m_drops  = 0;
            for (int i = 0; i < 4; i++) m_slot[i] = '0;
        end else begin
            m_in     = {digit_select, write_this};
            m_took   = m_valid && frame_ready;
            m_loaded = 1'b0;
            if (m_in == m_reg && $countones(~m_reg[10:7]) == 1 && (m_edge - m_since) == STABLE) begin
                m_idx = 0;
                for (int i = 0; i < 4; i++) if (!m_reg[7+i]) m_idx = i;
                m_slot[m_idx] = model_decode(m_reg[6:0]);
                m_seen[m_idx] = 1'b1;
                if (m_seen == 4'hF) begin
                    m_seen = 4'h0;
                    if (!m_valid || frame_ready) begin
                        for (int i = 0; i < 4; i++) begin
                            m_data[4*i +: 4] = m_slot[i][3:0];
                            m_fblank[i]      = m_slot[i][4];
                            m_ferr[i]        = m_slot[i][5];
                        end
                        m_loaded = 1'b1;
                    end else if (m_drops < 255) begin
                        m_drops++;
                    end
                end
            end
            if (m_loaded) m_valid = 1'b1;
            else if (m_took) m_valid = 1'b0;
            if (m_in != m_reg) begin
                m_reg   = m_in;
                m_since = m_edge;
            end
            m_edge++;
        end
    end

    // ---------------- compare process ----------------
    logic [23:0] dut_frames [$];
    int          valid_cycles = 0;

    always @(negedge clock) begin
        check_output("frame_valid", 32'(frame_valid), 32'(m_valid));
        if (m_valid || !reset_n) begin
            check_output("frame_data",  32'(frame_data),  32'(m_data));
            check_output("frame_blank", 32'(frame_blank), 32'(m_fblank));
            check_output("frame_err",   32'(frame_err),   32'(m_ferr));
        end
`ifdef SEG7_DROP_CNT_EN
        check_output("drop_count", 32'(drop_count), 32'(m_drops));
`endif
        if (frame_valid) valid_cycles++;
        if (reset_n && frame_valid && frame_ready) dut_frames.push_back({frame_data, frame_blank, frame_err});
    end

    // ---------------- stimulus ----------------
    task automatic apply_stimulus(input logic [3:0] sel, input logic [6:0] seg, input int cycles);
        digit_select = sel;
        write_this   = seg;
        repeat (cycles) @(posedge clock);
        #1;
    endtask

    task automatic scan_digit(input int idx, input logic [6:0] seg, input int cycles);
        logic [3:0] s;
        s = 4'b0001 << idx;
        apply_stimulus(~s, seg, cycles);
    endtask

    int base_frames;
    int base_valid;

    initial begin
        reset_n      = 1'b0;
        frame_ready  = 1'b0;
        digit_select = 4'hF;
        write_this   = 7'h7F;
        repeat (3) @(posedge clock);
        #1;
        check_output("reset_valid", 32'(frame_valid), 32'h0);
        check_output("reset_data",  32'(frame_data),  32'h0);
        reset_n = 1'b1;
        apply_stimulus(4'hF, 7'h7F, 3);

        // Plain scan 1,2,3,4 with the consumer always ready.
        frame_ready = 1'b1;
        base_frames = dut_frames.size();
        base_valid  = valid_cycles;
        for (int d = 0; d < 4; d++) scan_digit(d, glyph(d + 1), 6);
        apply_stimulus(4'hF, 7'h7F, 4);
        check_output("t1_count", 32'(dut_frames.size() - base_frames), 32'd1);
        check_output("t1_frame", 32'(dut_frames[$]), 32'h4321_00);
        check_output("t1_valid_cycles", 32'(valid_cycles - base_valid), 32'd1);

        // Short-lived glyph on digit 0 must not be captured.
        base_frames = dut_frames.size();
        scan_digit(0, glyph(8), 2);
        scan_digit(0, glyph(5), 6);
        scan_digit(1, glyph(10), 6);
        scan_digit(2, glyph(11), 6);
        scan_digit(3, glyph(12), 6);
        apply_stimulus(4'hF, 7'h7F, 4);
        check_output("t2_count", 32'(dut_frames.size() - base_frames), 32'd1);
        check_output("t2_frame", 32'(dut_frames[$]), 32'hCBA5_00);

        // Two simultaneous enables is not a slot; partial frame survives.
        base_frames = dut_frames.size();
        scan_digit(0, glyph(7), 6);
        scan_digit(1, glyph(8), 6);
        scan_digit(2, glyph(9), 6);
        apply_stimulus(4'b1100, glyph(0), 10);
        check_output("t3_no_frame", 32'(dut_frames.size() - base_frames), 32'd0);
        check_output("t3_valid_low", 32'(frame_valid), 32'h0);
        scan_digit(3, glyph(13), 6);
        apply_stimulus(4'hF, 7'h7F, 4);
        check_output("t3_count", 32'(dut_frames.size() - base_frames), 32'd1);
        check_output("t3_frame", 32'(dut_frames[$]), 32'hD987_00);

        // Blank and unrecognised patterns.
        scan_digit(0, glyph(0), 6);
        scan_digit(1, 7'b0101010, 6);
        scan_digit(2, 7'h7F, 6);
        scan_digit(3, glyph(0), 6);
        apply_stimulus(4'hF, 7'h7F, 4);
        check_output("t4_frame", 32'(dut_frames[$]), {8'h0, 16'h0000, 4'b0100, 4'b0010});

        // Stalled consumer: first frame held, second dropped.
        frame_ready = 1'b0;
        base_frames = dut_frames.size();
        scan_digit(0, glyph(14), 6);
        scan_digit(1, glyph(15), 6);
        scan_digit(2, glyph(0), 6);
        scan_digit(3, glyph(1), 6);
        scan_digit(0, glyph(5), 6);
        scan_digit(1, glyph(6), 6);
        scan_digit(2, glyph(7), 6);
        scan_digit(3, glyph(8), 6);
        check_output("t5_held_valid", 32'(frame_valid), 32'h1);
        check_output("t5_held_data", 32'(frame_data), 32'h10FE);
        check_output("t5_no_transfer", 32'(dut_frames.size() - base_frames), 32'd0);
`ifdef SEG7_DROP_CNT_EN
        check_output("t5_drop_count", 32'(drop_count), 32'd1);
`endif
        // Third frame completes on the same edge the consumer accepts.
        scan_digit(0, glyph(9), 6);
        scan_digit(1, glyph(10), 6);
        scan_digit(2, glyph(11), 6);
        scan_digit(3, glyph(12), STABLE);
        frame_ready = 1'b1;
        scan_digit(3, glyph(12), 1);
        check_output("t5_same_edge_valid", 32'(frame_valid), 32'h1);
        check_output("t5_same_edge_data", 32'(frame_data), 32'hCBA9);
        check_output("t5_first_taken", 32'(dut_frames[$]), 32'h10FE_00);
        apply_stimulus(4'hF, 7'h7F, 3);
        check_output("t5_third_taken", 32'(dut_frames[$]), 32'hCBA9_00);
        check_output("t5_valid_fell", 32'(frame_valid), 32'h0);

        // Reset after three captured slots discards them.
        base_frames = dut_frames.size();
        for (int d = 0; d < 3; d++) scan_digit(d, glyph(5), 6);
        reset_n = 1'b0;
        apply_stimulus(4'hF, 7'h7F, 3);
        check_output("t6_reset_valid", 32'(frame_valid), 32'h0);
        check_output("t6_reset_data", 32'(frame_data), 32'h0);
        reset_n = 1'b1;
        apply_stimulus(4'hF, 7'h7F, 2);
        scan_digit(3, glyph(15), 6);
        scan_digit(2, glyph(3), 6);
        scan_digit(1, glyph(2), 6);
        scan_digit(0, glyph(1), 6);
        apply_stimulus(4'hF, 7'h7F, 4);
        check_output("t6_count", 32'(dut_frames.size() - base_frames), 32'd1);
        check_output("t6_frame", 32'(dut_frames[$]), 32'hF321_00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
